umi_regfile_responder: RTL and testbench
========================================

# umi_regfile_responder

UMI request responder backed by a small DW-wide register file; it is the target end of the UMI request/response link that `lumi_tx_ready`/`lumi_rx_ready` carry. It accepts read, write and posted-write requests on a UMI request-in port and returns read/write responses on a UMI response-out port. Typical placement: on a LUMI receiver's `umi_req_out`, with its response port feeding the LUMI transmitter's `umi_resp_in`, so loopback benches exercise full request/response round trips.

## Interface
- DW, 128, data width in bits; byte lanes = DW/8
- CW, 32, command width
- AW, 64, address width
- DEPTH, 16, number of DW-wide words in the register file; power of two
- clk  in  1  clock; single clock domain
- nreset  in  1  reset, synchronous, active-low
- umi_req_in_valid / _cmd / _dstaddr / _srcaddr / _data  in  1/CW/AW/AW/DW  request channel
- umi_req_in_ready  out  1  request ready
- umi_resp_out_valid / _cmd / _dstaddr / _srcaddr / _data  out  1/CW/AW/AW/DW  response channel
- umi_resp_out_ready  in  1  response ready

## Operation
- Decoded cmd fields: opcode [4:0], size [7:5], len [15:8], eom [22], err [26:25], hostid [31:27].
- Opcodes: REQ_READ 5'h01, REQ_WRITE 5'h03, REQ_POSTED 5'h05, RESP_READ 5'h02, RESP_WRITE 5'h04.
- Derived values: off = dstaddr[log2(DW/8)-1:0]; idx = next log2(DEPTH) bits; hi = remaining upper bits; nbytes = (len+1) << size, computed at 16 bits to avoid overflow.
- A request is legal when hi == 0, size <= log2(DW/8), and off + nbytes <= DW/8.
- Legal write or posted write:
  - bytes off..off+nbytes-1 of word idx take req data bytes 0..nbytes-1 (LSB-aligned input);
  - other bytes of the word are unchanged.
- Legal read: response data bytes 0..nbytes-1 = word idx bytes off..off+nbytes-1; upper response bytes are 0.
- Illegal request: no register update; response data = 0; response err = 2'b11. Legal requests respond with err = 2'b00.
- Response cmd:
  - opcode = RESP_READ for reads, RESP_WRITE for writes;
  - size, len and hostid copied from the request; eom = 1; all other bits 0.
- Response addresses: resp dstaddr = req srcaddr; resp srcaddr = req dstaddr.
- Posted writes, legal or illegal, never generate a response.
- Any other opcode is consumed and dropped: no response, no register update.
- Response register is a single entry, states EMPTY and FULL:
  - EMPTY -> FULL on acceptance of a read or write;
  - FULL -> EMPTY on resp valid & ready with no new response-producing acceptance in that cycle;
  - FULL stays FULL when it drains and refills in the same cycle.

## Timing
- Reset values (synchronous, active-low): umi_resp_out_valid = 0; resp cmd/addr/data = 0; every register-file word = 0; umi_req_in_ready = 0 while nreset = 0.
- umi_req_in_ready = ~resp_full | umi_resp_out_ready (combinational) when out of reset.
- A request is accepted on the clock edge where valid & ready.
- Write takes effect at that edge. A read accepted one cycle later sees the new data.
- Response valid asserts the cycle after acceptance (latency 1). It holds with stable cmd/addr/data until ready is seen.
- Sustained throughput is one request per cycle when umi_resp_out_ready stays 1.
- Read data is captured at acceptance. Later writes do not alter a pending response.
- umi_resp_out_valid must not depend combinationally on umi_resp_out_ready.
- Reset asserted mid-transaction discards any pending response and clears the register file on the next edge.

## Test plan
- Write then read: REQ_WRITE dst 0x20, size 2, len 0, data 0xDEADBEEF, then REQ_READ same address, srcaddr 0x1000.
  - First response: RESP_WRITE, err 0.
  - Second response: RESP_READ, dst 0x1000, data 0xDEADBEEF.
- Byte merge: full 16-byte write at 0x0 of 0x00112233_44556677_8899AABB_CCDDEEFF, then posted 1-byte 0x5A at 0x3, then 4-byte read at 0x0.
  - Posted write produces no response.
  - Read data = 0x5ADDEEFF.
- Illegal requests, each returning err 2'b11 and leaving the target word unchanged:
  - read at dstaddr 0x100 (hi != 0) -> err 2'b11, data 0;
  - write size 2, len 3 at off 0x4 (overrun) -> err 2'b11, target word unchanged.
- Backpressure: resp_ready held 0 for 10 cycles with 3 reads queued.
  - One response is held stable throughout; req_ready = 0.
  - After release, responses arrive in order, no drops or duplicates.
- Full throughput: 32 back-to-back reads with resp_ready = 1 -> 32 responses on 32 consecutive cycles.
- Reset mid-flight: assert nreset = 0 while a response is pending.
  - resp_valid = 0 next cycle.
  - A subsequent read of any word returns 0.

Source files
------------

// File: rtl/umi_regfile_responder.sv
// UMI target backed by a DEPTH x DW register file: serves reads, writes and
// posted writes, and returns responses through a single-entry response register.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_EMPTY | no response pending; requests accepted unconditionally
//   ST_FULL  | response held on umi_resp_out_*; new request needs ready
module umi_regfile_responder #(
    parameter int DW    = 128,
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_req_in_valid,
    input  logic [CW-1:0] umi_req_in_cmd,
    input  logic [AW-1:0] umi_req_in_dstaddr,
    input  logic [AW-1:0] umi_req_in_srcaddr,
    input  logic [DW-1:0] umi_req_in_data,
    output logic          umi_req_in_ready,
    output logic          umi_resp_out_valid,
    output logic [CW-1:0] umi_resp_out_cmd,
    output logic [AW-1:0] umi_resp_out_dstaddr,
    output logic [AW-1:0] umi_resp_out_srcaddr,
    output logic [DW-1:0] umi_resp_out_data,
    input  logic          umi_resp_out_ready
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cmd_q, cmd_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] src_q, src_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic [4:0]    req_opcode;
    logic [2:0]    req_size;
    logic [7:0]    req_len;
    logic [4:0]    req_hostid;
    logic [OW-1:0] req_off;
    logic [IW-1:0] req_idx;
    logic          req_hi_zero;
    logic [15:0]   req_nbytes;
    logic [16:0]   req_span;
    logic          req_legal;
    logic          is_read, is_write, is_posted;
    logic          req_accept, resp_load;

    logic [NB-1:0] wr_byte_en;
    logic [DW-1:0] wr_data_sh, wr_merged;
    logic [DW-1:0] rd_word_sh, rd_data;
    logic [CW-1:0] resp_cmd;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^umi_req_in_cmd[26:16];

    assign req_opcode  = umi_req_in_cmd[4:0];
    assign req_size    = umi_req_in_cmd[7:5];
    assign req_len     = umi_req_in_cmd[15:8];
    assign req_hostid  = umi_req_in_cmd[31:27];
    assign req_off     = umi_req_in_dstaddr[OW-1:0];
    assign req_idx     = umi_req_in_dstaddr[OW+IW-1:OW];
    assign req_hi_zero = (umi_req_in_dstaddr[AW-1:OW+IW] == '0);

    // 16-bit length math: (255+1) << 7 still fits, so no wrap can fake legality
    assign req_nbytes = (16'(req_len) + 16'd1) << req_size;
    assign req_span   = 17'(req_off) + 17'(req_nbytes);
    assign req_legal  = req_hi_zero && (int'(req_size) <= OW) && (req_span <= 17'(NB));

    assign is_read   = (req_opcode == REQ_READ);
    assign is_write  = (req_opcode == REQ_WRITE);
    assign is_posted = (req_opcode == REQ_POSTED);

    assign umi_req_in_ready = nreset && ((state_q == ST_EMPTY) || umi_resp_out_ready);
    assign req_accept       = umi_req_in_valid && umi_req_in_ready;

    assign wr_data_sh = umi_req_in_data << {req_off, 3'b000};
    assign rd_word_sh = mem_q[req_idx] >> {req_off, 3'b000};

    always_comb begin
        wr_byte_en = '0;
        wr_merged  = mem_q[req_idx];
        rd_data    = '0;
        for (int b = 0; b < NB; b++) begin
            wr_byte_en[b] = (17'(b) >= 17'(req_off)) && (17'(b) < req_span);
            if (wr_byte_en[b]) begin
                wr_merged[8*b +: 8] = wr_data_sh[8*b +: 8];
            end
            if (req_legal && (17'(b) < 17'(req_nbytes))) begin
                rd_data[8*b +: 8] = rd_word_sh[8*b +: 8];
            end
        end
    end

    always_comb begin
        resp_cmd        = '0;
        resp_cmd[4:0]   = is_read ? RESP_READ : RESP_WRITE;
        resp_cmd[7:5]   = req_size;
        resp_cmd[15:8]  = req_len;
        resp_cmd[22]    = 1'b1;
        resp_cmd[26:25] = req_legal ? 2'b00 : 2'b11;
        resp_cmd[31:27] = req_hostid;
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        dst_d     = dst_q;
        src_d     = src_q;
        data_d    = data_q;
        mem_d     = mem_q;
        resp_load = req_accept && (is_read || is_write);

        if (req_accept && (is_write || is_posted) && req_legal) begin
            mem_d[req_idx] = wr_merged;
        end

        if (resp_load) begin
            state_d = ST_FULL;
            cmd_d   = resp_cmd;
            dst_d   = umi_req_in_srcaddr;
            src_d   = umi_req_in_dstaddr;
            data_d  = is_read ? rd_data : '0;
        end else if ((state_q == ST_FULL) && umi_resp_out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_EMPTY;
            cmd_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            data_q  <= data_d;
            mem_q   <= mem_d;
        end
    end

    assign umi_resp_out_valid   = (state_q == ST_FULL);
    assign umi_resp_out_cmd     = cmd_q;
    assign umi_resp_out_dstaddr = dst_q;
    assign umi_resp_out_srcaddr = src_q;
    assign umi_resp_out_data    = data_q;

endmodule

// File: tb/tb_umi_regfile_responder.sv
// Bench for umi_regfile_responder: directed scenarios plus randomized traffic,
// checked every cycle against a byte-array register model and a response queue.
module tb_umi_regfile_responder;

    logic          clk;
    logic          nreset;
    logic          req_valid;
    logic [31:0]   req_cmd;
    logic [63:0]   req_dst;
    logic [63:0]   req_src;
    logic [127:0]  req_data;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_cmd;
    logic [63:0]   resp_dst;
    logic [63:0]   resp_src;
    logic [127:0]  resp_data;
    logic          resp_ready;

    umi_regfile_responder dut (
        .clk                  (clk),
        .nreset               (nreset),
        .umi_req_in_valid     (req_valid),
        .umi_req_in_cmd       (req_cmd),
        .umi_req_in_dstaddr   (req_dst),
        .umi_req_in_srcaddr   (req_src),
        .umi_req_in_data      (req_data),
        .umi_req_in_ready     (req_ready),
        .umi_resp_out_valid   (resp_valid),
        .umi_resp_out_cmd     (resp_cmd),
        .umi_resp_out_dstaddr (resp_dst),
        .umi_resp_out_srcaddr (resp_src),
        .umi_resp_out_data    (resp_data),
        .umi_resp_out_ready   (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  cmd;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [127:0] data;
    } resp_t;

    logic [7:0]   mem_m [16][16];
    resp_t        exp_q [$];
    int           n_err;
    int           n_checks;
    int           pop_cnt;
    logic [31:0]  last_cmd;
    logic [63:0]  last_dst;
    logic [127:0] last_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                           input logic [7:0] len, input logic [4:0] hostid);
        return {hostid, 2'b00, 2'b00, 1'b0, 6'b0, len, size, op};
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 16; w++)
            for (int b = 0; b < 16; b++)
                mem_m[w][b] = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [31:0] c, input logic [63:0] d,
                               input logic [63:0] s, input logic [127:0] dat);
        logic [4:0] op;
        int         size, nb, off, idx;
        bit         legal;
        resp_t      r;
        op    = c[4:0];
        size  = int'(c[7:5]);
        nb    = (int'(c[15:8]) + 1) * (1 << size);
        off   = int'(d[3:0]);
        idx   = int'(d[7:4]);
        legal = ((d >> 8) == 64'd0) && (size <= 4) && (off + nb <= 16);
        r.cmd  = {c[31:27], (legal ? 2'b00 : 2'b11), 2'b00, 1'b1, 6'b0, c[15:8], c[7:5],
                  (op == 5'h01 ? 5'h02 : 5'h04)};
        r.dst  = s;
        r.src  = d;
        r.data = '0;
        if ((op == 5'h03 || op == 5'h05) && legal)
            for (int i = 0; i < nb; i++) mem_m[idx][off+i] = dat[8*i +: 8];
        if (op == 5'h01 && legal)
            for (int i = 0; i < nb; i++) r.data[8*i +: 8] = mem_m[idx][off+i];
        if (op == 5'h01 || op == 5'h03) exp_q.push_back(r);
    endtask

    // one clock: drive at negedge, check outputs 1ns later, update model at posedge
    task automatic step(input logic v, input logic [31:0] c, input logic [63:0] d,
                        input logic [63:0] s, input logic [127:0] dat,
                        input logic rr, input logic rst_n, output logic acc);
        logic exp_ready;
        @(negedge clk);
        nreset     = rst_n;
        req_valid  = v;
        req_cmd    = c;
        req_dst    = d;
        req_src    = s;
        req_data   = dat;
        resp_ready = rr;
        #1;
        exp_ready = rst_n && ((exp_q.size() == 0) || rr);
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        chk("resp_valid", 128'(resp_valid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("resp_cmd", 128'(resp_cmd), 128'(exp_q[0].cmd));
            chk("resp_dst", 128'(resp_dst), 128'(exp_q[0].dst));
            chk("resp_src", 128'(resp_src), 128'(exp_q[0].src));
            chk("resp_data", resp_data, exp_q[0].data);
        end
        if (resp_valid && rr) begin
            pop_cnt++;
            last_cmd  = resp_cmd;
            last_dst  = resp_dst;
            last_data = resp_data;
        end
        @(posedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
            acc = v && exp_ready;
            if (acc) model_apply(c, d, s, dat);
        end
    endtask

    task automatic idle(input logic rr);
        logic acc;
        step(1'b0, '0, '0, '0, '0, rr, 1'b1, acc);
    endtask

    task automatic send(input logic [31:0] c, input logic [63:0] d,
                        input logic [63:0] s, input logic [127:0] dat);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) step(1'b1, c, d, s, dat, 1'b1, 1'b1, acc);
        if (!acc) chk("send_timeout", 128'(acc), 128'(1));
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] c;
        int          r;
        logic [4:0]  op;
        r = $urandom_range(0, 9);
        if (r <= 2)      op = 5'h01;
        else if (r <= 5) op = 5'h03;
        else if (r <= 7) op = 5'h05;
        else             op = 5'($urandom_range(0, 31));
        c      = $urandom;
        c[4:0] = op;
        c[7:5] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        c[15:8] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
        return c;
    endfunction

    initial begin
        logic         acc;
        logic [31:0]  c;
        logic [63:0]  d, s;
        logic [127:0] dat;
        logic [127:0] hold_data;
        int           p0;

        n_err = 0; n_checks = 0; pop_cnt = 0;
        last_cmd = '0; last_dst = '0; last_data = '0;
        nreset = 1'b0; req_valid = 1'b0; req_cmd = '0; req_dst = '0;
        req_src = '0; req_data = '0; resp_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        step(1'b1, mk_cmd(5'h01, 3'd2, 8'd0, 5'd0), '0, '0, '0, 1'b1, 1'b0, acc);

        // write then read
        send(mk_cmd(5'h03, 3'd2, 8'd0, 5'd3), 64'h20, 64'h2000, 128'hDEADBEEF);
        send(mk_cmd(5'h01, 3'd2, 8'd0, 5'd3), 64'h20, 64'h1000, '0);
        chk("wr_resp_op", 128'(last_cmd[4:0]), 128'(5'h04));
        chk("wr_resp_err", 128'(last_cmd[26:25]), 128'(2'b00));
        idle(1'b1);
        chk("rd_resp_op", 128'(last_cmd[4:0]), 128'(5'h02));
        chk("rd_resp_dst", 128'(last_dst), 128'(64'h1000));
        chk("rd_resp_data", last_data, 128'hDEADBEEF);

        // byte merge with posted write
        send(mk_cmd(5'h03, 3'd4, 8'd0, 5'd1), 64'h0, 64'h40, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        idle(1'b1);
        p0 = pop_cnt;
        send(mk_cmd(5'h05, 3'd0, 8'd0, 5'd1), 64'h3, 64'h40, 128'h5A);
        idle(1'b1);
        chk("posted_no_resp", 128'(pop_cnt - p0), 128'(0));
        send(mk_cmd(5'h01, 3'd2, 8'd0, 5'd1), 64'h0, 64'h40, '0);
        idle(1'b1);
        chk("merge_data", last_data, 128'h5ADDEEFF);

        // illegal requests
        send(mk_cmd(5'h01, 3'd2, 8'd0, 5'd2), 64'h100, 64'h50, '0);
        idle(1'b1);
        chk("ill_hi_err", 128'(last_cmd[26:25]), 128'(2'b11));
        chk("ill_hi_data", last_data, 128'h0);
        send(mk_cmd(5'h03, 3'd2, 8'd3, 5'd2), 64'h4, 64'h50, {4{32'hA5A5A5A5}});
        idle(1'b1);
        chk("ill_ovr_err", 128'(last_cmd[26:25]), 128'(2'b11));
        send(mk_cmd(5'h01, 3'd4, 8'd0, 5'd2), 64'h0, 64'h50, '0);
        idle(1'b1);
        chk("ill_ovr_word", last_data, 128'h00112233_44556677_8899AABB_5ADDEEFF);

        // backpressure: three reads queued behind a stalled response port
        p0 = pop_cnt;
        step(1'b1, mk_cmd(5'h01, 3'd4, 8'd0, 5'd4), 64'h00, 64'hA0, '0, 1'b0, 1'b1, acc);
        chk("bp_first_acc", 128'(acc), 128'(1));
        hold_data = resp_data;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, mk_cmd(5'h01, 3'd4, 8'd0, 5'd4), 64'h20, 64'hA1, '0, 1'b0, 1'b1, acc);
            if (k == 0) hold_data = resp_data;
            chk("bp_hold", resp_data, hold_data);
            chk("bp_no_acc", 128'(acc), 128'(0));
        end
        send(mk_cmd(5'h01, 3'd4, 8'd0, 5'd4), 64'h20, 64'hA1, '0);
        send(mk_cmd(5'h01, 3'd4, 8'd0, 5'd4), 64'h30, 64'hA2, '0);
        idle(1'b1);
        idle(1'b1);
        chk("bp_resp_cnt", 128'(pop_cnt - p0), 128'(3));
        chk("bp_last_dst", 128'(last_dst), 128'(64'hA2));

        // full throughput
        p0 = pop_cnt;
        for (int k = 0; k < 32; k++) begin
            step(1'b1, mk_cmd(5'h01, 3'd2, 8'd0, 5'd5), 64'(k % 16) << 4, 64'(k), '0, 1'b1, 1'b1, acc);
            chk("thru_acc", 128'(acc), 128'(1));
        end
        idle(1'b1);
        chk("thru_cnt", 128'(pop_cnt - p0), 128'(32));

        // reset while a response is pending
        send(mk_cmd(5'h03, 3'd2, 8'd0, 5'd6), 64'h50, 64'h60, 128'h12345678);
        step(1'b1, mk_cmd(5'h01, 3'd2, 8'd0, 5'd6), 64'h50, 64'h60, '0, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("rst_valid", 128'(resp_valid), 128'(0));
        send(mk_cmd(5'h01, 3'd2, 8'd0, 5'd6), 64'h50, 64'h60, '0);
        idle(1'b1);
        chk("rst_word", last_data, 128'h0);

        // randomized traffic, requests held until accepted
        c = rand_cmd(); d = 64'h0; s = 64'h0; dat = '0; acc = 1'b1;
        for (int k = 0; k < 600; k++) begin
            logic v;
            if (acc) begin
                c   = rand_cmd();
                d   = ($urandom_range(0, 15) == 0) ? {32'($urandom), 32'($urandom)}
                                                   : 64'($urandom_range(0, 63));
                s   = {32'($urandom), 32'($urandom)};
                dat = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            end
            v = ($urandom_range(0, 3) != 0);
            step(v, c, d, s, dat, ($urandom_range(0, 9) < 7), 1'b1, acc);
            if (!v) acc = 1'b1;
        end
        repeat (3) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
